baser_66b_lock_checker: RTL and testbench
=========================================

Name: baser_66b_lock_checker

Overview:
- Parametrised successor to the fixed 4-block 66b checker: accepts NB 66b blocks per beat, qualified by a valid strobe.
- Runs a sync-header block-lock FSM, classifies each block as data, control, invalid-SH or invalid-format, and keeps saturating statistics counters.
- Sits after the 257b transcoder checker (or directly on a 66b lane) in the BASE-R verification chain.
- Drives lock status and a lock-loss counter for the testbench scoreboard.

Parameters:
- NB, 4: 66b blocks per beat, 1..8.
- FRAME_WIDTH, 66: bits per block; SH is [65:64], block type is [63:56].
- CNT_WIDTH, 32: width of every statistics counter.
- LOCK_CNT, 64: valid-SH blocks needed to lock; must be a multiple of NB.
- WINDOW, 64: blocks per bad-SH monitoring window; must be a multiple of NB.
- BAD_MAX, 16: bad-SH blocks within one window that cause lock loss.

Ports:
- clk, in, 1: clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_valid, in, 1: beat qualifier.
- i_rx_coded, in, NB*FRAME_WIDTH: block k occupies [k*66 +: 66]; block 0 is first in time.
- i_clr_cnt, in, 1: synchronous clear of the statistics counters.
- o_lock, out, 1: block lock achieved.
- o_block_count, out, CNT_WIDTH: blocks counted while locked.
- o_data_count, out, CNT_WIDTH: SH=01 blocks.
- o_ctrl_count, out, CNT_WIDTH: SH=10 blocks with a legal type.
- o_inv_sh_count, out, CNT_WIDTH: SH of 00 or 11.
- o_inv_format_count, out, CNT_WIDTH: SH=10 block with an illegal type byte.
- o_lock_loss_count, out, CNT_WIDTH: LOCKED to SEARCH transitions.
- o_state, out, 2: 0=RESET, 1=SEARCH, 2=LOCKED.

Behaviour:
- Reset (i_rst=1 at a clk edge):
  - All counters = 0, o_lock = 0, state = RESET, internal sh_cnt/win_cnt/bad_cnt = 0.
  - Reset overrides i_valid and i_clr_cnt in the same cycle.
  - Reset mid-lock drops o_lock on the next edge and does not increment o_lock_loss_count.
- Per-beat classification (combinational, per block k):
  - Data: SH = 2'b01.
  - Control: SH = 2'b10 and type in {1E,2D,33,66,55,78,4B,87,99,AA,B4,CC,D2,E1,FF}.
  - Inv_format: SH = 2'b10 and any other type byte.
  - Inv_sh: SH = 2'b00 or 2'b11.
  - nbad = number of inv_sh blocks in the beat (0..NB).
- Beats with i_valid=0 change nothing, including FSM counters.
- RESET state: on the first clock after reset release, go to SEARCH unconditionally.
- SEARCH state:
  - On a valid beat: if nbad > 0, sh_cnt = 0; else sh_cnt += NB.
  - When the updated sh_cnt >= LOCK_CNT: go to LOCKED, set o_lock = 1 on the same edge, clear win_cnt and bad_cnt.
  - A beat containing any bad SH never contributes toward lock.
- LOCKED state, on a valid beat:
  - win_cnt += NB; bad_cnt += nbad.
  - If the updated bad_cnt >= BAD_MAX: go to SEARCH, set o_lock = 0, o_lock_loss_count += 1, clear sh_cnt/win_cnt/bad_cnt.
  - Else if the updated win_cnt == WINDOW: clear win_cnt and bad_cnt.
  - Simultaneous bad_cnt threshold and window end: lock loss wins.
- Statistics:
  - Updated only for valid beats whose state at the start of the cycle is LOCKED.
  - The beat that causes lock loss is still counted.
  - The beat that achieves lock is not counted.
  - Each counter adds its per-beat count (0..NB), registered, so values appear 1 cycle after the beat.
- Arithmetic:
  - All counters saturate at 2^CNT_WIDTH-1; an add that would overflow leaves the counter at max.
  - Invariant while not saturated: block = data + ctrl + inv_sh + inv_format.
- i_clr_cnt:
  - Zeroes the six statistics counters; the FSM is unaffected.
  - If asserted with a valid locked beat, the counters take that beat's counts, not zero (clear-then-add).
- o_state and o_lock are registered; o_lock == (o_state == LOCKED).

Test Plan:
- Lock acquisition:
  - Stimulus: NB=4, reset then 16 valid beats of SH=01 data.
  - Required: o_lock rises on the edge that samples beat 16; block_count stays 0; 10 more beats give block_count = data_count = 40.
- Lock loss:
  - Stimulus: locked, then 4 beats each holding 4 SH=11 blocks.
  - Required: o_lock falls after the 4th beat; lock_loss_count = 1; inv_sh_count = 16.
- Window reset:
  - Stimulus: locked; each 16-beat window carries 15 bad-SH blocks; run 3 windows.
  - Required: o_lock stays 1; inv_sh_count = 45; lock_loss_count = 0.
- Format check:
  - Stimulus: locked beat {SH10/type 1E, SH10/type 00, SH01, SH10/type FF}.
  - Required: ctrl += 2, inv_format += 1, data += 1, block += 4.
- SEARCH interruption and valid gap:
  - Stimulus: 10 good beats, 1 beat with one bad SH, 15 good beats, 5 idle cycles (i_valid=0), then 1 good beat.
  - Required: o_lock rises only after the final beat (sh_cnt 60 → 64); o_lock is still 0 during the idle cycles.
- Saturation and clear:
  - Stimulus: CNT_WIDTH=4, locked data beats.
  - Required: block_count sticks at 15; i_clr_cnt alone → 0; i_clr_cnt with a valid beat → 4; i_rst mid-lock → o_lock = 0 and lock_loss_count stays 0.

Source files
------------

// File: rtl/baser_66b_lock_checker_if.sv
// ---------------------------------------------------------------------------
// baser_66b_lock_checker_if
// Bus bundle for the BASE-R 66b block-lock checker.
//   i_valid            beat qualifier
//   i_rx_coded         NB x FRAME_WIDTH blocks, block 0 in the low bits
//   i_clr_cnt          synchronous clear of the statistics counters
//   o_lock             block lock achieved
//   o_*_count          saturating statistics counters
//   o_lock_loss_count  LOCKED -> SEARCH transitions
//   o_state            0=RESET 1=SEARCH 2=LOCKED
// master: the block source/consumer (testbench); slave: the checker.
// ---------------------------------------------------------------------------
interface baser_66b_lock_checker_if #(
    parameter int NB          = 4,
    parameter int FRAME_WIDTH = 66,
    parameter int CNT_WIDTH   = 32
);
    logic                        i_valid;
    logic [NB*FRAME_WIDTH-1:0]   i_rx_coded;
    logic                        i_clr_cnt;
    logic                        o_lock;
    logic [CNT_WIDTH-1:0]        o_block_count;
    logic [CNT_WIDTH-1:0]        o_data_count;
    logic [CNT_WIDTH-1:0]        o_ctrl_count;
    logic [CNT_WIDTH-1:0]        o_inv_sh_count;
    logic [CNT_WIDTH-1:0]        o_inv_format_count;
    logic [CNT_WIDTH-1:0]        o_lock_loss_count;
    logic [1:0]                  o_state;

    modport master (
        output i_valid, i_rx_coded, i_clr_cnt,
        input  o_lock, o_block_count, o_data_count, o_ctrl_count,
               o_inv_sh_count, o_inv_format_count, o_lock_loss_count, o_state
    );

    modport slave (
        input  i_valid, i_rx_coded, i_clr_cnt,
        output o_lock, o_block_count, o_data_count, o_ctrl_count,
               o_inv_sh_count, o_inv_format_count, o_lock_loss_count, o_state
    );
endinterface

// File: rtl/baser_66b_lock_checker.sv
// ---------------------------------------------------------------------------
// baser_66b_lock_checker
// Sync-header block-lock FSM plus per-block classification and saturating
// statistics for NB 66b blocks per beat.
// Ports:
//   clk    clock
//   i_rst  synchronous active-high reset
//   bus    baser_66b_lock_checker_if.slave (beat inputs, lock/statistics out)
// ---------------------------------------------------------------------------
module baser_66b_lock_checker #(
    parameter int NB          = 4,
    parameter int FRAME_WIDTH = 66,
    parameter int CNT_WIDTH   = 32,
    parameter int LOCK_CNT    = 64,
    parameter int WINDOW      = 64,
    parameter int BAD_MAX     = 16
) (
    input  logic                          clk,
    input  logic                          i_rst,
    baser_66b_lock_checker_if.slave       bus
);
    // Per-beat block counts fit 0..8; FSM counters only need to reach
    // LOCK_CNT/WINDOW/BAD_MAX plus one beat of headroom.
    localparam int NW = 4;
    localparam int FW = 16;
    localparam logic [FW-1:0] NB_C   = FW'(NB);
    localparam logic [FW-1:0] LOCK_C = FW'(LOCK_CNT);
    localparam logic [FW-1:0] WIN_C  = FW'(WINDOW);
    localparam logic [FW-1:0] BAD_C  = FW'(BAD_MAX);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 lock_q;
    logic [FW-1:0]        sh_q, sh_d, win_q, win_d, bad_q, bad_d;
    logic [FW-1:0]        sh_upd_s, win_upd_s, bad_upd_s;
    logic                 loss_s;
    logic [NW-1:0]        n_data_s, n_ctrl_s, n_ish_s, n_fmt_s, n_blk_s, n_loss_s;
    logic                 stat_en_s;
    logic [CNT_WIDTH-1:0] blk_q, dat_q, ctl_q, ish_q, fmt_q, los_q;
    logic [CNT_WIDTH-1:0] blk_d, dat_d, ctl_d, ish_d, fmt_d, los_d;

    // Legal control-block type bytes.
    function automatic logic is_ctrl_type(input logic [7:0] ty);
        logic ok;
        case (ty)
            8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
            8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Add a per-beat count, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [NW-1:0]        b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(CNT_WIDTH + 1 - NW){1'b0}}, b};
        if (sum[CNT_WIDTH]) begin
            return {CNT_WIDTH{1'b1}};
        end else begin
            return sum[CNT_WIDTH-1:0];
        end
    endfunction

    // Clear-then-add: a clear on a counted beat leaves just that beat's count.
    function automatic logic [CNT_WIDTH-1:0] next_cnt(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic                 clr,
                                                      input logic                 en,
                                                      input logic [NW-1:0]        inc);
        logic [CNT_WIDTH-1:0] base;
        if (clr) begin
            base = '0;
        end else begin
            base = cur;
        end
        if (en) begin
            return sat_add(base, inc);
        end else begin
            return base;
        end
    endfunction

    // Classify every block of the beat and count each class.
    always_comb begin
        n_data_s = 4'd0;
        n_ctrl_s = 4'd0;
        n_ish_s  = 4'd0;
        n_fmt_s  = 4'd0;
        for (int k = 0; k < NB; k++) begin
            case (bus.i_rx_coded[k*FRAME_WIDTH+64 +: 2])
                2'b01: n_data_s = n_data_s + 4'd1;
                2'b10: begin
                    if (is_ctrl_type(bus.i_rx_coded[k*FRAME_WIDTH+56 +: 8])) begin
                        n_ctrl_s = n_ctrl_s + 4'd1;
                    end else begin
                        n_fmt_s = n_fmt_s + 4'd1;
                    end
                end
                default: n_ish_s = n_ish_s + 4'd1;
            endcase
        end
    end

    // Lock FSM next state and internal SH/window/bad counters.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        win_d     = win_q;
        bad_d     = bad_q;
        loss_s    = 1'b0;
        sh_upd_s  = sh_q + NB_C;
        win_upd_s = win_q + NB_C;
        bad_upd_s = bad_q + FW'(n_ish_s);
        case (state_q)
            ST_RESET: begin
                state_d = ST_SEARCH;
                sh_d    = '0;
                win_d   = '0;
                bad_d   = '0;
            end
            ST_SEARCH: begin
                if (bus.i_valid) begin
                    // Any bad SH in the beat restarts the good-header run.
                    if (n_ish_s != 4'd0) begin
                        sh_upd_s = '0;
                    end else begin
                        sh_upd_s = sh_q + NB_C;
                    end
                    if (sh_upd_s >= LOCK_C) begin
                        state_d = ST_LOCKED;
                        sh_d    = '0;
                        win_d   = '0;
                        bad_d   = '0;
                    end else begin
                        sh_d = sh_upd_s;
                    end
                end else begin
                    sh_d = sh_q;
                end
            end
            ST_LOCKED: begin
                if (bus.i_valid) begin
                    // Threshold is checked before window end so loss wins a tie.
                    if (bad_upd_s >= BAD_C) begin
                        state_d = ST_SEARCH;
                        loss_s  = 1'b1;
                        sh_d    = '0;
                        win_d   = '0;
                        bad_d   = '0;
                    end else if (win_upd_s == WIN_C) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_upd_s;
                        bad_d = bad_upd_s;
                    end
                end else begin
                    win_d = win_q;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Statistics next values; only beats seen in LOCKED are counted.
    always_comb begin
        stat_en_s = bus.i_valid && (state_q == ST_LOCKED);
        n_blk_s   = NW'(NB);
        n_loss_s  = {3'b000, loss_s};
        blk_d     = next_cnt(blk_q, bus.i_clr_cnt, stat_en_s, n_blk_s);
        dat_d     = next_cnt(dat_q, bus.i_clr_cnt, stat_en_s, n_data_s);
        ctl_d     = next_cnt(ctl_q, bus.i_clr_cnt, stat_en_s, n_ctrl_s);
        ish_d     = next_cnt(ish_q, bus.i_clr_cnt, stat_en_s, n_ish_s);
        fmt_d     = next_cnt(fmt_q, bus.i_clr_cnt, stat_en_s, n_fmt_s);
        los_d     = next_cnt(los_q, bus.i_clr_cnt, stat_en_s, n_loss_s);
    end

    // State, lock flag and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_RESET;
            lock_q  <= 1'b0;
            sh_q    <= '0;
            win_q   <= '0;
            bad_q   <= '0;
            blk_q   <= '0;
            dat_q   <= '0;
            ctl_q   <= '0;
            ish_q   <= '0;
            fmt_q   <= '0;
            los_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= (state_d == ST_LOCKED);
            sh_q    <= sh_d;
            win_q   <= win_d;
            bad_q   <= bad_d;
            blk_q   <= blk_d;
            dat_q   <= dat_d;
            ctl_q   <= ctl_d;
            ish_q   <= ish_d;
            fmt_q   <= fmt_d;
            los_q   <= los_d;
        end
    end

    assign bus.o_lock             = lock_q;
    assign bus.o_state            = state_q;
    assign bus.o_block_count      = blk_q;
    assign bus.o_data_count       = dat_q;
    assign bus.o_ctrl_count       = ctl_q;
    assign bus.o_inv_sh_count     = ish_q;
    assign bus.o_inv_format_count = fmt_q;
    assign bus.o_lock_loss_count  = los_q;
endmodule

// File: tb/tb_baser_66b_lock_checker.sv
// ---------------------------------------------------------------------------
// tb_baser_66b_lock_checker
// Two checkers share one stimulus stream: dut_a with 32-bit counters and
// dut_b with 4-bit counters for the saturation cases. Stimulus pushes
// hand-computed expectations tagged with the cycle they become visible;
// a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_baser_66b_lock_checker;
    localparam int NB = 4;
    localparam int FW = 66;

    typedef struct {
        int          at;
        int          tag;
        bit          sel;
        logic        lock;
        logic [1:0]  st;
        logic [31:0] blk, dat, ctl, ish, fmt, los;
    } exp_t;

    exp_t q[$];

    logic                 clk = 1'b0;
    logic                 rst_s = 1'b1;
    logic                 valid_s = 1'b0;
    logic                 clr_s = 1'b0;
    logic [NB*FW-1:0]     data_s = '0;
    int                   pcyc = 0;
    int                   nvec = 0;
    int                   nfail = 0;

    logic [65:0] blk_d, blk_b, blk_c1e, blk_c00, blk_cff;
    logic [NB*FW-1:0] beat_good, beat_bad, beat_one_bad, beat_15th, beat_fmt;

    baser_66b_lock_checker_if #(.NB(NB), .FRAME_WIDTH(FW), .CNT_WIDTH(32)) bus_a ();
    baser_66b_lock_checker_if #(.NB(NB), .FRAME_WIDTH(FW), .CNT_WIDTH(4))  bus_b ();

    assign bus_a.i_valid    = valid_s;
    assign bus_a.i_clr_cnt  = clr_s;
    assign bus_a.i_rx_coded = data_s;
    assign bus_b.i_valid    = valid_s;
    assign bus_b.i_clr_cnt  = clr_s;
    assign bus_b.i_rx_coded = data_s;

    baser_66b_lock_checker #(.NB(NB), .FRAME_WIDTH(FW), .CNT_WIDTH(32),
        .LOCK_CNT(64), .WINDOW(64), .BAD_MAX(16)) dut_a (
        .clk(clk), .i_rst(rst_s), .bus(bus_a.slave));

    baser_66b_lock_checker #(.NB(NB), .FRAME_WIDTH(FW), .CNT_WIDTH(4),
        .LOCK_CNT(64), .WINDOW(64), .BAD_MAX(16)) dut_b (
        .clk(clk), .i_rst(rst_s), .bus(bus_b.slave));

    always #5 clk = ~clk;

    // Cycle index used to tag when each expectation becomes visible.
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic cmp(input int tag, input string fld, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL chk%0d %s: got %0d want %0d", tag, fld, got, want);
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= pcyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.at < pcyc) begin
                nvec++;
                nfail++;
                $display("FAIL chk%0d missed: got cycle %0d want cycle %0d", e.tag, pcyc, e.at);
            end else if (e.sel == 1'b0) begin
                cmp(e.tag, "lock",  {31'd0, bus_a.o_lock}, {31'd0, e.lock});
                cmp(e.tag, "state", {30'd0, bus_a.o_state}, {30'd0, e.st});
                cmp(e.tag, "block", bus_a.o_block_count, e.blk);
                cmp(e.tag, "data",  bus_a.o_data_count, e.dat);
                cmp(e.tag, "ctrl",  bus_a.o_ctrl_count, e.ctl);
                cmp(e.tag, "inv_sh", bus_a.o_inv_sh_count, e.ish);
                cmp(e.tag, "inv_fmt", bus_a.o_inv_format_count, e.fmt);
                cmp(e.tag, "loss",  bus_a.o_lock_loss_count, e.los);
            end else begin
                cmp(e.tag, "b_lock",  {31'd0, bus_b.o_lock}, {31'd0, e.lock});
                cmp(e.tag, "b_state", {30'd0, bus_b.o_state}, {30'd0, e.st});
                cmp(e.tag, "b_block", {28'd0, bus_b.o_block_count}, e.blk);
                cmp(e.tag, "b_data",  {28'd0, bus_b.o_data_count}, e.dat);
                cmp(e.tag, "b_ctrl",  {28'd0, bus_b.o_ctrl_count}, e.ctl);
                cmp(e.tag, "b_inv_sh", {28'd0, bus_b.o_inv_sh_count}, e.ish);
                cmp(e.tag, "b_inv_fmt", {28'd0, bus_b.o_inv_format_count}, e.fmt);
                cmp(e.tag, "b_loss",  {28'd0, bus_b.o_lock_loss_count}, e.los);
            end
        end
    end

    // Drive one cycle of inputs away from the sampling edge.
    task automatic step(input logic r, input logic v, input logic [NB*FW-1:0] d, input logic c);
        @(negedge clk);
        rst_s   = r;
        valid_s = v;
        data_s  = d;
        clr_s   = c;
    endtask

    // Expected outputs after the edge that samples the last driven cycle.
    task automatic expect_out(input int tag, input bit sel, input logic lock, input logic [1:0] st,
                              input int blk, input int dat, input int ctl, input int ish,
                              input int fmt, input int los);
        exp_t e;
        e.at = pcyc + 1; e.tag = tag; e.sel = sel; e.lock = lock; e.st = st;
        e.blk = blk; e.dat = dat; e.ctl = ctl; e.ish = ish; e.fmt = fmt; e.los = los;
        q.push_back(e);
    endtask

    initial begin
        blk_d   = {2'b01, 64'hA5A5_5A5A_0F0F_F0F0};
        blk_b   = {2'b11, 64'h0};
        blk_c1e = {2'b10, 8'h1E, 56'h0};
        blk_c00 = {2'b10, 8'h00, 56'h0};
        blk_cff = {2'b10, 8'hFF, 56'h0};
        beat_good    = {blk_d, blk_d, blk_d, blk_d};
        beat_bad     = {blk_b, blk_b, blk_b, blk_b};
        beat_one_bad = {blk_d, blk_d, blk_b, blk_d};
        beat_15th    = {blk_d, blk_b, blk_b, blk_b};
        beat_fmt     = {blk_cff, blk_d, blk_c00, blk_c1e};

        // Reset, then release into SEARCH
        step(1'b1, 1'b0, beat_good, 1'b0);
        expect_out(1, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 0, 0);
        expect_out(2, 1'b1, 1'b0, 2'd0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, beat_good, 1'b0);
        expect_out(3, 1'b0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 0);

        // Lock acquisition: 16 good beats
        repeat (15) step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(4, 1'b0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(5, 1'b0, 1'b1, 2'd2, 0, 0, 0, 0, 0, 0);
        repeat (10) step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(6, 1'b0, 1'b1, 2'd2, 40, 40, 0, 0, 0, 0);

        // Lock loss: 16 bad SH across 4 beats
        repeat (3) step(1'b0, 1'b1, beat_bad, 1'b0);
        expect_out(7, 1'b0, 1'b1, 2'd2, 52, 40, 0, 12, 0, 0);
        step(1'b0, 1'b1, beat_bad, 1'b0);
        expect_out(8, 1'b0, 1'b0, 2'd1, 56, 40, 0, 16, 0, 1);

        // Relock; SEARCH beats and the locking beat are not counted
        repeat (16) step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(9, 1'b0, 1'b1, 2'd2, 56, 40, 0, 16, 0, 1);
        step(1'b0, 1'b0, beat_good, 1'b1);
        expect_out(10, 1'b0, 1'b1, 2'd2, 0, 0, 0, 0, 0, 0);

        // Window reset: 15 bad SH per 64-block window, 3 windows
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 16; b++) begin
                if (b < 3)       step(1'b0, 1'b1, beat_bad, 1'b0);
                else if (b == 3) step(1'b0, 1'b1, beat_15th, 1'b0);
                else             step(1'b0, 1'b1, beat_good, 1'b0);
            end
        end
        expect_out(11, 1'b0, 1'b1, 2'd2, 192, 147, 0, 45, 0, 0);

        // Format check
        step(1'b0, 1'b1, beat_fmt, 1'b0);
        expect_out(12, 1'b0, 1'b1, 2'd2, 196, 148, 2, 45, 1, 0);

        // Reset mid-lock overrides valid and clear, no lock-loss count
        step(1'b1, 1'b1, beat_good, 1'b1);
        expect_out(13, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 0, 0);
        expect_out(14, 1'b1, 1'b0, 2'd0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, beat_good, 1'b0);

        // SEARCH interruption and idle gap
        repeat (10) step(1'b0, 1'b1, beat_good, 1'b0);
        step(1'b0, 1'b1, beat_one_bad, 1'b0);
        repeat (15) step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(15, 1'b0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 0);
        repeat (5) step(1'b0, 1'b0, beat_good, 1'b0);
        expect_out(16, 1'b0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(17, 1'b0, 1'b1, 2'd2, 0, 0, 0, 0, 0, 0);

        // Saturation on the 4-bit instance
        repeat (3) step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(18, 1'b1, 1'b1, 2'd2, 12, 12, 0, 0, 0, 0);
        step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(19, 1'b1, 1'b1, 2'd2, 15, 15, 0, 0, 0, 0);
        step(1'b0, 1'b1, beat_good, 1'b0);
        expect_out(20, 1'b1, 1'b1, 2'd2, 15, 15, 0, 0, 0, 0);
        expect_out(21, 1'b0, 1'b1, 2'd2, 20, 20, 0, 0, 0, 0);

        // Clear alone, then clear with a counted beat
        step(1'b0, 1'b0, beat_good, 1'b1);
        expect_out(22, 1'b1, 1'b1, 2'd2, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, beat_good, 1'b1);
        expect_out(23, 1'b1, 1'b1, 2'd2, 4, 4, 0, 0, 0, 0);
        expect_out(24, 1'b0, 1'b1, 2'd2, 4, 4, 0, 0, 0, 0);

        // Reset mid-lock on the saturating instance
        step(1'b1, 1'b1, beat_good, 1'b0);
        expect_out(25, 1'b1, 1'b0, 2'd0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, beat_good, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            nvec++;
            nfail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
